instr_seq: RTL and testbench
============================

Name: instr_seq

Overview:
- Instruction register plus multi-cycle fetch/decode/execute sequencer for the 8-bit computer.
- Sits directly downstream of memory: it latches the instruction byte from mem_out.
- Sits directly upstream of Control and shiftregs: it drives opcode[2:0] and immediate[4:0].
- Time-gates Control's raw write enables and issues the single PC advance pulse per instruction.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address-stable to data-valid; legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_out  in  8  byte read from memory (instruction in fetch, data in load).
- halt  in  1  level; when high, the sequencer stops at the next instruction boundary.
- ctrl_regWE  in  1  raw regWE from Control.
- ctrl_accWE  in  1  raw accWE from Control.
- ctrl_memWE  in  1  raw memWE from Control.
- ctrl_lw  in  1  raw lw from Control.
- opcode  out  3  ir[7:5].
- immediate  out  5  ir[4:0].
- ir  out  8  full instruction register.
- addr_sel  out  1  memory address mux select: 0 = PC addr, 1 = data address (lw / sw).
- regWE  out  1  gated register-file write enable.
- accWE  out  1  gated accumulator write enable.
- memWE  out  1  gated memory write enable.
- pc_en  out  1  one-cycle PC update pulse; PC applies brnch_yes on this pulse.
- busy  out  1  high in every state except HALT.

Behaviour:
- Reset (rst=1 on a clock edge) has priority over everything:
  - state <= FETCH, ir <= 8'h00, wait counter <= 0.
  - addr_sel, regWE, accWE, memWE and pc_en are all 0; busy = 1 after reset.
  - Reset mid-instruction abandons the instruction and emits no write and no pc_en.
- States: FETCH, DECODE, EXEC, LOAD, WB, HALT.
- FETCH:
  - addr_sel=0; the counter increments each cycle.
  - When counter==MEM_LAT-1: ir <= mem_out, counter <= 0, go to DECODE.
  - Fetch takes MEM_LAT cycles.
- DECODE:
  - One cycle, no outputs asserted; Control settles on the new opcode.
  - ctrl_* are sampled at the end of this cycle into registered flags.
- EXEC:
  - If lw flag=0: assert regWE/accWE/memWE equal to the sampled flags for exactly 1 cycle, assert pc_en in the same cycle, then go to FETCH (or HALT if halt=1).
  - memWE asserts with addr_sel=1.
  - If lw flag=1: addr_sel=1, no enables asserted, go to LOAD.
- LOAD:
  - addr_sel=1; wait MEM_LAT cycles using the counter, then go to WB.
- WB:
  - addr_sel=1; assert regWE (and accWE if its sampled flag is set) for 1 cycle, plus pc_en, then go to FETCH (or HALT if halt=1).
- HALT:
  - All enables 0, busy=0, ir holds.
  - Leave to FETCH on the first cycle halt=0.
- halt is only examined at instruction boundaries (the end of EXEC or WB). An instruction already in flight always completes.
- Instruction latency: non-load = MEM_LAT+2 cycles; load = 2*MEM_LAT+3 cycles.
- Invariants:
  - Exactly one pc_en per instruction.
  - Enables are never asserted outside EXEC/WB.
  - At most one of memWE and regWE is high in any cycle; if Control raises both, memWE wins and regWE is suppressed.
- Counter is 3 bits and resets to 0 on every state entry; it never wraps.
- All outputs are registered except opcode/immediate, which are wired from ir.

Optional Feature:
- INSTR_SEQ_STEP_EN defined:
  - Adds input step (1 bit).
  - After each instruction boundary the sequencer enters HALT regardless of halt.
  - A single-cycle step=1 in HALT advances exactly one instruction; while halt=1, step is ignored.
- Undefined: no step port; HALT is entered only via halt.

Decomposition:
- Shared package cpu8_pkg holds:
  - state enum seq_state_t (FETCH, DECODE, EXEC, LOAD, WB, HALT);
  - OPC_W=3, IMM_W=5, DATA_W=8;
  - the opcode field positions OPC_MSB=7 and OPC_LSB=5.
- One sub-module is natural: lat_counter, the MEM_LAT wait counter with clear/done. Everything else stays in instr_seq.

Test Plan:
- Reset, then mem_out=8'hA3 with MEM_LAT=1 and all ctrl_*=0 -> ir=8'hA3, opcode=3'b101, immediate=5'b00011 at DECODE; pc_en pulses once at cycle 3.
- ctrl_regWE=1, ctrl_lw=0 -> regWE high exactly 1 cycle coincident with pc_en; next instruction fetched; 3 cycles per instruction.
- ctrl_lw=1, ctrl_regWE=1, MEM_LAT=2 -> addr_sel=1 through EXEC/LOAD/WB; regWE pulses only in WB; instruction takes 7 cycles.
- ctrl_memWE=1 and ctrl_regWE=1 together -> memWE=1, regWE=0, addr_sel=1 in EXEC.
- halt raised during LOAD -> instruction completes with WB and pc_en, then HALT with busy=0; halt dropped -> FETCH on the next cycle.
- rst asserted in EXEC with ctrl_accWE=1 -> no accWE and no pc_en; next cycle state FETCH, ir=8'h00. With INSTR_SEQ_STEP_EN, a single step pulse -> exactly one pc_en, then HALT.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit computer: field widths, opcode field
// position, sequencer state encoding and the sampled Control-flag bundle.
package cpu8_pkg;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned IMM_W   = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        LOAD,
        WB,
        HALT
    } seq_state_t;

    // Control's raw enables, captured at the end of DECODE
    typedef struct packed {
        logic regwe;
        logic accwe;
        logic memwe;
        logic lw;
    } ctrl_flags_t;

endpackage

// File: rtl/lat_counter.sv
// Memory-latency wait counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to 0 (state entry)
//   en       : advance count by one
//   done_c   : combinational, high when count has reached MEM_LAT-1
module lat_counter
    import cpu8_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done_c
);

    logic [CNT_W-1:0] count;

    // Count register; clear takes precedence so every state entry starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done_c = (count == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/instr_seq.sv
// Instruction register and fetch/decode/execute sequencer.
// Latches the instruction byte from memory, exposes opcode/immediate to
// Control, time-gates Control's raw write enables and issues one PC advance
// pulse per instruction.
//   clk, rst          : clock, synchronous active-high reset
//   mem_out           : memory read data
//   halt              : stop at the next instruction boundary (level)
//   step              : (INSTR_SEQ_STEP_EN only) advance one instruction from HALT
//   ctrl_regWE/accWE/memWE/lw : raw enables from Control
//   opcode, immediate : ir fields (combinational from ir)
//   ir                : instruction register
//   addr_sel          : 0 = PC address, 1 = data address
//   regWE/accWE/memWE : gated write enables
//   pc_en             : one-cycle PC update pulse
//   busy              : low only in HALT
// Optional build macro: INSTR_SEQ_STEP_EN (single-step mode).
module instr_seq
    import cpu8_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              halt,
`ifdef INSTR_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              ctrl_regWE,
    input  logic              ctrl_accWE,
    input  logic              ctrl_memWE,
    input  logic              ctrl_lw,
    output logic [OPC_W-1:0]  opcode,
    output logic [IMM_W-1:0]  immediate,
    output logic [DATA_W-1:0] ir,
    output logic              addr_sel,
    output logic              regWE,
    output logic              accWE,
    output logic              memWE,
    output logic              pc_en,
    output logic              busy
);

    seq_state_t  state_q, state_n, boundary_c;
    ctrl_flags_t flags_q, flags_n;
    logic [DATA_W-1:0] ir_n;
    logic addr_sel_n, regwe_n, accwe_n, memwe_n, pc_en_n, busy_n;
    logic resume_c, cnt_clr_c, cnt_en_c, cnt_done_c;

    lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .en     (cnt_en_c),
        .done_c (cnt_done_c)
    );

    // Where an instruction boundary leads, and what releases HALT
`ifdef INSTR_SEQ_STEP_EN
    assign boundary_c = HALT;
    assign resume_c   = step & ~halt;
`else
    assign boundary_c = halt ? HALT : FETCH;
    assign resume_c   = ~halt;
`endif

    // Counter restarts on any state change and only runs while waiting on memory
    assign cnt_clr_c = (state_n != state_q);
    assign cnt_en_c  = (state_q == FETCH) || (state_q == LOAD);

    // Next state, next ir/flags, and the registered outputs for the state being entered
    always_comb begin
        state_n    = state_q;
        flags_n    = flags_q;
        ir_n       = ir;
        addr_sel_n = 1'b0;
        regwe_n    = 1'b0;
        accwe_n    = 1'b0;
        memwe_n    = 1'b0;
        pc_en_n    = 1'b0;

        case (state_q)
            FETCH: begin
                if (cnt_done_c) begin
                    ir_n    = mem_out;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                flags_n.regwe = ctrl_regWE;
                flags_n.accwe = ctrl_accWE;
                flags_n.memwe = ctrl_memWE;
                flags_n.lw    = ctrl_lw;
                state_n       = EXEC;
            end
            EXEC:    state_n = flags_q.lw ? LOAD : boundary_c;
            LOAD:    if (cnt_done_c) state_n = WB;
            WB:      state_n = boundary_c;
            HALT:    if (resume_c) state_n = FETCH;
            default: state_n = FETCH;
        endcase

        // Outputs are decoded from the next state so they line up with it
        case (state_n)
            EXEC: begin
                if (flags_n.lw) begin
                    addr_sel_n = 1'b1;
                end else begin
                    // memWE wins over regWE when Control raises both
                    memwe_n    = flags_n.memwe;
                    regwe_n    = flags_n.regwe & ~flags_n.memwe;
                    accwe_n    = flags_n.accwe;
                    addr_sel_n = flags_n.memwe;
                    pc_en_n    = 1'b1;
                end
            end
            LOAD: addr_sel_n = 1'b1;
            WB: begin
                addr_sel_n = 1'b1;
                regwe_n    = 1'b1;
                accwe_n    = flags_n.accwe;
                pc_en_n    = 1'b1;
            end
            default: ;
        endcase

        busy_n = (state_n != HALT);
    end

    // State, instruction register, sampled flags and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            ir       <= '0;
            flags_q  <= '0;
            addr_sel <= 1'b0;
            regWE    <= 1'b0;
            accWE    <= 1'b0;
            memWE    <= 1'b0;
            pc_en    <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state_q  <= state_n;
            ir       <= ir_n;
            flags_q  <= flags_n;
            addr_sel <= addr_sel_n;
            regWE    <= regwe_n;
            accWE    <= accwe_n;
            memWE    <= memwe_n;
            pc_en    <= pc_en_n;
            busy     <= busy_n;
        end
    end

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign immediate = ir[IMM_W-1:0];

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: one instance at MEM_LAT=1, one at
// MEM_LAT=2, shared stimulus, per-instruction scoreboard.
module tb_instr_seq;
    import cpu8_pkg::*;

    typedef struct {
        int          cycles;
        logic [7:0]  ir;
        int          regwe;
        int          accwe;
        int          memwe;
        int          asel;
        int          stray;
        int          both;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, halt;
    logic [7:0] mem_out;
    logic       c_reg, c_acc, c_mem, c_lw;
`ifdef INSTR_SEQ_STEP_EN
    logic       step;
`endif

    logic [2:0] op1, op2;
    logic [4:0] imm1, imm2;
    logic [7:0] ir1, ir2;
    logic       as1, rw1, aw1, mw1, pc1, bz1;
    logic       as2, rw2, aw2, mw2, pc2, bz2;

    instr_seq #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_out(mem_out), .halt(halt),
`ifdef INSTR_SEQ_STEP_EN
        .step(step),
`endif
        .ctrl_regWE(c_reg), .ctrl_accWE(c_acc), .ctrl_memWE(c_mem), .ctrl_lw(c_lw),
        .opcode(op1), .immediate(imm1), .ir(ir1), .addr_sel(as1),
        .regWE(rw1), .accWE(aw1), .memWE(mw1), .pc_en(pc1), .busy(bz1)
    );

    instr_seq #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_out(mem_out), .halt(halt),
`ifdef INSTR_SEQ_STEP_EN
        .step(step),
`endif
        .ctrl_regWE(c_reg), .ctrl_accWE(c_acc), .ctrl_memWE(c_mem), .ctrl_lw(c_lw),
        .opcode(op2), .immediate(imm2), .ir(ir2), .addr_sel(as2),
        .regWE(rw2), .accWE(aw2), .memWE(mw2), .pc_en(pc2), .busy(bz2)
    );

    // Observed instance selector
    logic       sel;
    logic [2:0] s_op;
    logic [4:0] s_imm;
    logic [7:0] s_ir;
    logic       s_as, s_rw, s_aw, s_mw, s_pc, s_bz;
    always_comb begin
        s_op  = sel ? op2  : op1;
        s_imm = sel ? imm2 : imm1;
        s_ir  = sel ? ir2  : ir1;
        s_as  = sel ? as2  : as1;
        s_rw  = sel ? rw2  : rw1;
        s_aw  = sel ? aw2  : aw1;
        s_mw  = sel ? mw2  : mw1;
        s_pc  = sel ? pc2  : pc1;
        s_bz  = sel ? bz2  : bz1;
    end

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q[$];

    // Stimulus word: {instr[7:0], regWE, accWE, memWE, lw}
    localparam logic [11:0] EXEC_TBL [7] = '{
        12'h21_8, 12'h42_4, 12'h63_C, 12'h84_2, 12'hC5_A, 12'hE6_0, 12'h07_9
    };
    localparam logic [11:0] LOAD_TBL [5] = '{
        12'h9F_9, 12'hB0_D, 12'h1E_A, 12'h55_8, 12'hFF_3
    };

    // Expected per-instruction behaviour from the specification
    function automatic rec_t model(input int ml, input logic [11:0] v);
        rec_t e;
        logic r, a, m, l;
        r = v[3]; a = v[2]; m = v[1]; l = v[0];
        e.ir = v[11:4];
        e.stray = 0;
        e.both = 0;
        if (l) begin
            e.cycles = 2 * ml + 3;
            e.regwe  = 1;
            e.accwe  = a ? 1 : 0;
            e.memwe  = 0;
            e.asel   = ml + 2;
        end else begin
            e.cycles = ml + 2;
            e.regwe  = (r && !m) ? 1 : 0;
            e.accwe  = a ? 1 : 0;
            e.memwe  = m ? 1 : 0;
            e.asel   = m ? 1 : 0;
        end
        return e;
    endfunction

    // Drives one instruction and records what the selected DUT does until pc_en
    task automatic run_instr(input logic [11:0] v, input int start, input int halt_at,
                             output rec_t obs);
        int  n;
        bit  done;
        mem_out = v[11:4];
        c_reg = v[3]; c_acc = v[2]; c_mem = v[1]; c_lw = v[0];
        obs.cycles = -1; obs.ir = '0; obs.regwe = 0; obs.accwe = 0;
        obs.memwe = 0; obs.asel = 0; obs.stray = 0; obs.both = 0;
        n = start;
`ifdef INSTR_SEQ_STEP_EN
        if (s_bz == 1'b0) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            n = 1;
        end
`endif
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            n++;
            if (halt_at != 0 && n == halt_at) halt = 1'b1;
            if (s_as) obs.asel++;
            if (s_rw) obs.regwe++;
            if (s_aw) obs.accwe++;
            if (s_mw) obs.memwe++;
            if ((s_rw || s_aw || s_mw) && !s_pc) obs.stray++;
            if (s_rw && s_mw) obs.both++;
            if (s_pc) begin
                obs.cycles = n;
                obs.ir = s_ir;
                done = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b0; mem_out = 8'hFF;
        c_reg = 1'b1; c_acc = 1'b1; c_mem = 1'b1; c_lw = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ir1 !== 8'h00) begin failures++; $display("FAIL reset_ir1 got=%h exp=00", ir1); end
        checks++; if ({as1, rw1, aw1, mw1, pc1} !== 5'b0) begin failures++; $display("FAIL reset_en1 got=%b exp=00000", {as1, rw1, aw1, mw1, pc1}); end
        checks++; if (bz1 !== 1'b1) begin failures++; $display("FAIL reset_busy1 got=%b exp=1", bz1); end
        checks++; if (ir2 !== 8'h00) begin failures++; $display("FAIL reset_ir2 got=%h exp=00", ir2); end
        checks++; if ({as2, rw2, aw2, mw2, pc2} !== 5'b0) begin failures++; $display("FAIL reset_en2 got=%b exp=00000", {as2, rw2, aw2, mw2, pc2}); end
        checks++; if (bz2 !== 1'b1) begin failures++; $display("FAIL reset_busy2 got=%b exp=1", bz2); end
    endtask

    // First instruction out of reset at MEM_LAT=1: DECODE in cycle 2, pc_en in cycle 3
    task automatic test_first_fetch();
        sel = 1'b0;
        mem_out = 8'hA3;
        c_reg = 1'b0; c_acc = 1'b0; c_mem = 1'b0; c_lw = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_ir !== 8'hA3) begin failures++; $display("FAIL ff_ir got=%h exp=a3", s_ir); end
        checks++; if (s_op !== 3'b101) begin failures++; $display("FAIL ff_opcode got=%b exp=101", s_op); end
        checks++; if (s_imm !== 5'b00011) begin failures++; $display("FAIL ff_imm got=%b exp=00011", s_imm); end
        checks++; if (s_pc !== 1'b0) begin failures++; $display("FAIL ff_pc_decode got=%b exp=0", s_pc); end
        @(negedge clk);
        checks++; if (s_pc !== 1'b1) begin failures++; $display("FAIL ff_pc_cycle3 got=%b exp=1", s_pc); end
        checks++; if ({s_rw, s_aw, s_mw} !== 3'b000) begin failures++; $display("FAIL ff_en got=%b exp=000", {s_rw, s_aw, s_mw}); end
    endtask

    task automatic test_exec_stream();
        rec_t o, e;
        logic [11:0] v;
        sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            v = EXEC_TBL[i];
            exp_q.push_back(model(1, v));
            run_instr(v, 0, 0, o);
            e = exp_q.pop_front();
            checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL exec[%0d] cycles got=%0d exp=%0d", i, o.cycles, e.cycles); end
            checks++; if (o.ir !== e.ir) begin failures++; $display("FAIL exec[%0d] ir got=%h exp=%h", i, o.ir, e.ir); end
            checks++; if (o.regwe !== e.regwe) begin failures++; $display("FAIL exec[%0d] regWE got=%0d exp=%0d", i, o.regwe, e.regwe); end
            checks++; if (o.accwe !== e.accwe) begin failures++; $display("FAIL exec[%0d] accWE got=%0d exp=%0d", i, o.accwe, e.accwe); end
            checks++; if (o.memwe !== e.memwe) begin failures++; $display("FAIL exec[%0d] memWE got=%0d exp=%0d", i, o.memwe, e.memwe); end
            checks++; if (o.asel !== e.asel) begin failures++; $display("FAIL exec[%0d] addr_sel got=%0d exp=%0d", i, o.asel, e.asel); end
            checks++; if (o.stray !== e.stray) begin failures++; $display("FAIL exec[%0d] stray_en got=%0d exp=%0d", i, o.stray, e.stray); end
            checks++; if (o.both !== e.both) begin failures++; $display("FAIL exec[%0d] reg_mem_both got=%0d exp=%0d", i, o.both, e.both); end
        end
    endtask

    // Reset in the cycle that would enter EXEC: no write, no pc_en, ir cleared
    task automatic test_reset_exec();
        rec_t o, e;
        sel = 1'b0;
        do_reset();
        mem_out = 8'h5C;
        c_reg = 1'b0; c_acc = 1'b1; c_mem = 1'b0; c_lw = 1'b0;
        @(negedge clk);
        checks++; if (s_ir !== 8'h5C) begin failures++; $display("FAIL rx_ir_fetched got=%h exp=5c", s_ir); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_aw !== 1'b0) begin failures++; $display("FAIL rx_accWE got=%b exp=0", s_aw); end
        checks++; if (s_pc !== 1'b0) begin failures++; $display("FAIL rx_pc_en got=%b exp=0", s_pc); end
        checks++; if (s_ir !== 8'h00) begin failures++; $display("FAIL rx_ir got=%h exp=00", s_ir); end
        checks++; if (s_bz !== 1'b1) begin failures++; $display("FAIL rx_busy got=%b exp=1", s_bz); end
        rst = 1'b0;
        exp_q.push_back(model(1, 12'h3C_0));
        run_instr(12'h3C_0, 1, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL rx_next cycles got=%0d exp=%0d", o.cycles, e.cycles); end
        checks++; if (o.accwe !== e.accwe) begin failures++; $display("FAIL rx_next accWE got=%0d exp=%0d", o.accwe, e.accwe); end
    endtask

    task automatic test_load_stream();
        rec_t o, e;
        logic [11:0] v;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v = LOAD_TBL[i];
            exp_q.push_back(model(2, v));
            run_instr(v, (i == 0) ? 1 : 0, 0, o);
            e = exp_q.pop_front();
            checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL load[%0d] cycles got=%0d exp=%0d", i, o.cycles, e.cycles); end
            checks++; if (o.ir !== e.ir) begin failures++; $display("FAIL load[%0d] ir got=%h exp=%h", i, o.ir, e.ir); end
            checks++; if (o.regwe !== e.regwe) begin failures++; $display("FAIL load[%0d] regWE got=%0d exp=%0d", i, o.regwe, e.regwe); end
            checks++; if (o.accwe !== e.accwe) begin failures++; $display("FAIL load[%0d] accWE got=%0d exp=%0d", i, o.accwe, e.accwe); end
            checks++; if (o.memwe !== e.memwe) begin failures++; $display("FAIL load[%0d] memWE got=%0d exp=%0d", i, o.memwe, e.memwe); end
            checks++; if (o.asel !== e.asel) begin failures++; $display("FAIL load[%0d] addr_sel got=%0d exp=%0d", i, o.asel, e.asel); end
            checks++; if (o.stray !== e.stray) begin failures++; $display("FAIL load[%0d] stray_en got=%0d exp=%0d", i, o.stray, e.stray); end
            checks++; if (o.both !== e.both) begin failures++; $display("FAIL load[%0d] reg_mem_both got=%0d exp=%0d", i, o.both, e.both); end
        end
    endtask

    // halt raised mid-LOAD: instruction completes, then HALT; release resumes FETCH
    task automatic test_halt();
        rec_t o, e;
        int pcs;
        sel = 1'b1;
        exp_q.push_back(model(2, 12'h9A_9));
        run_instr(12'h9A_9, 0, 5, o);
        e = exp_q.pop_front();
        checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL halt_load cycles got=%0d exp=%0d", o.cycles, e.cycles); end
        checks++; if (o.regwe !== e.regwe) begin failures++; $display("FAIL halt_load regWE got=%0d exp=%0d", o.regwe, e.regwe); end
        pcs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_pc) pcs++;
            checks++; if (s_bz !== 1'b0) begin failures++; $display("FAIL halt_busy[%0d] got=%b exp=0", k, s_bz); end
        end
        checks++; if (pcs !== 0) begin failures++; $display("FAIL halt_pc_en got=%0d exp=0", pcs); end
        checks++; if (s_ir !== 8'h9A) begin failures++; $display("FAIL halt_ir got=%h exp=9a", s_ir); end
        halt = 1'b0;
        @(negedge clk);
`ifdef INSTR_SEQ_STEP_EN
        checks++; if (s_bz !== 1'b0) begin failures++; $display("FAIL halt_release_step got=%b exp=0", s_bz); end
`else
        checks++; if (s_bz !== 1'b1) begin failures++; $display("FAIL halt_release got=%b exp=1", s_bz); end
`endif
        exp_q.push_back(model(2, 12'h47_4));
        run_instr(12'h47_4, 1, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL halt_resume cycles got=%0d exp=%0d", o.cycles, e.cycles); end
        checks++; if (o.ir !== e.ir) begin failures++; $display("FAIL halt_resume ir got=%h exp=%h", o.ir, e.ir); end
    endtask

`ifdef INSTR_SEQ_STEP_EN
    // step ignored under halt; one step advances exactly one instruction
    task automatic test_step();
        rec_t o, e;
        int pcs;
        sel = 1'b1;
        halt = 1'b1; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (s_bz !== 1'b0) begin failures++; $display("FAIL step_halt_ignored got=%b exp=0", s_bz); end
        halt = 1'b0;
        exp_q.push_back(model(2, 12'h6B_8));
        run_instr(12'h6B_8, 0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.cycles !== e.cycles) begin failures++; $display("FAIL step cycles got=%0d exp=%0d", o.cycles, e.cycles); end
        pcs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_pc) pcs++;
        end
        checks++; if (pcs !== 0) begin failures++; $display("FAIL step_extra_pc got=%0d exp=0", pcs); end
        checks++; if (s_bz !== 1'b0) begin failures++; $display("FAIL step_rehalt got=%b exp=0", s_bz); end
    endtask
`endif

    initial begin
        sel = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
        step = 1'b0;
`endif
        test_reset();
        test_first_fetch();
        test_exec_stream();
        test_reset_exec();
        test_load_stream();
        test_halt();
`ifdef INSTR_SEQ_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
